// File: rtl/mig_ui_emulator.sv
// Block-RAM backed responder for the DDR MIG app_* user interface, single-beat 128-bit lines.
// Optional macro MIG_UI_EMULATOR_BACKPRESSURE_EN adds LFSR-driven stalls on app_rdy / app_wdf_rdy.
module mig_ui_emulator #(
  parameter int CHUNK_PART   = 128,
  parameter int ADDRESS_SIZE = 28,
  parameter int ADDR_LSB     = 3,
  parameter int LINE_BITS    = 10,
  parameter int CALIB_CYCLES = 16,
  parameter int READ_LATENCY = 4,
  parameter int WDF_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDRESS_SIZE-1:0]   app_addr,
  input  logic [2:0]                app_cmd,
  input  logic                      app_en,
  output logic                      app_rdy,
  input  logic [CHUNK_PART-1:0]     app_wdf_data,
  input  logic [CHUNK_PART/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_wren,
  input  logic                      app_wdf_end,
  output logic                      app_wdf_rdy,
  output logic [CHUNK_PART-1:0]     app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      app_rd_data_end,
  output logic                      init_calib_complete,
  output logic                      cmd_error
);

  localparam int MASK_W = CHUNK_PART / 8;
  localparam int LINES  = 1 << LINE_BITS;
  localparam int PTR_W  = $clog2(WDF_DEPTH);
  localparam int CNT_W  = $clog2(CALIB_CYCLES + 1);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic {
    IDLE,
    WAIT_DATA
  } state_t;

  state_t                 state;
  logic [LINE_BITS-1:0]   wait_idx;
  logic                   calibrated;
  logic [CNT_W-1:0]       calib_cnt;

  logic [CHUNK_PART-1:0]  fifo_data [WDF_DEPTH];
  logic [MASK_W-1:0]      fifo_mask [WDF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         fifo_cnt;
  logic                   fifo_empty;
  logic                   fifo_full;

  logic [CHUNK_PART-1:0]  mem [LINES];
  logic [CHUNK_PART-1:0]  rd_pipe [READ_LATENCY-1];
  logic [READ_LATENCY-2:0] rd_vld;

  logic                   cmd_stall;
  logic                   data_stall;
  logic                   push;
  logic                   accept;
  logic                   wr_cmd;
  logic                   rd_cmd;
  logic                   bad_cmd;
  logic [LINE_BITS-1:0]   cmd_idx;

  logic                   commit;
  logic                   bypass;
  logic                   pop;
  logic                   fifo_wr;
  logic                   mem_we;
  logic [LINE_BITS-1:0]   commit_idx;
  logic [CHUNK_PART-1:0]  commit_data;
  logic [MASK_W-1:0]      commit_mask;

  // Single-beat lines make app_wdf_end redundant; upper address bits alias by design.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, app_wdf_end,
                           app_addr[ADDRESS_SIZE-1:ADDR_LSB+LINE_BITS],
                           app_addr[ADDR_LSB-1:0]};

`ifdef MIG_UI_EMULATOR_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; frozen until calibration completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (calibrated) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign cmd_stall  = (lfsr[1:0] == 2'b00);
  assign data_stall = (lfsr[3:2] == 2'b00);
`else
  assign cmd_stall  = 1'b0;
  assign data_stall = 1'b0;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(WDF_DEPTH));

  assign app_rdy     = calibrated && (state == IDLE) && !cmd_stall;
  assign app_wdf_rdy = calibrated && !fifo_full && !data_stall;
  assign init_calib_complete = calibrated;

  assign push    = app_wdf_wren && app_wdf_rdy;
  assign accept  = app_en && app_rdy;
  assign wr_cmd  = accept && (app_cmd == CMD_WRITE);
  assign rd_cmd  = accept && (app_cmd == CMD_READ);
  assign bad_cmd = accept && (app_cmd != CMD_WRITE) && (app_cmd != CMD_READ);
  assign cmd_idx = app_addr[ADDR_LSB +: LINE_BITS];

  // Pick the beat to commit: FIFO head if any, else the beat arriving this cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    commit      = 1'b0;
    bypass      = 1'b0;
    pop         = 1'b0;
    commit_idx  = cmd_idx;
    commit_data = fifo_data[rd_ptr];
    commit_mask = fifo_mask[rd_ptr];
    if (state == WAIT_DATA) begin
      if (push) begin
        commit      = 1'b1;
        bypass      = 1'b1;
        commit_idx  = wait_idx;
        commit_data = app_wdf_data;
        commit_mask = app_wdf_mask;
      end
    end else if (wr_cmd) begin
      if (!fifo_empty) begin
        commit = 1'b1;
        pop    = 1'b1;
      end else if (push) begin
        commit      = 1'b1;
        bypass      = 1'b1;
        commit_data = app_wdf_data;
        commit_mask = app_wdf_mask;
      end
    end
  end

  assign fifo_wr = push && !bypass;
  assign mem_we  = commit && reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      calib_cnt  <= '0;
      calibrated <= 1'b0;
    end else if (!calibrated) begin
      if (calib_cnt == CNT_W'(CALIB_CYCLES - 1)) begin
        calibrated <= 1'b1;
      end else begin
        calib_cnt <= calib_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_idx  <= '0;
      cmd_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_cmd && !commit) begin
            state    <= WAIT_DATA;
            wait_idx <= cmd_idx;
          end
        end
        WAIT_DATA: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bad_cmd) cmd_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage arrays have no reset; emptiness is tracked by the pointers, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= app_wdf_data;
      fifo_mask[wr_ptr] <= app_wdf_mask;
    end
  end

  // Byte-masked write port plus synchronous read feeding the data delay line.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!commit_mask[b]) mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
    rd_pipe[0] <= mem[cmd_idx];
    for (int i = 1; i < READ_LATENCY - 1; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld            <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data_end   <= 1'b0;
      app_rd_data       <= '0;
    end else begin
      rd_vld[0] <= rd_cmd;
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
      app_rd_data_valid <= rd_vld[READ_LATENCY-2];
      app_rd_data_end   <= rd_vld[READ_LATENCY-2];
      if (rd_vld[READ_LATENCY-2]) app_rd_data <= rd_pipe[READ_LATENCY-2];
    end
  end

endmodule

// File: tb/tb_mig_ui_emulator.sv
// Directed self-checking bench for mig_ui_emulator (default build, no backpressure).
module tb_mig_ui_emulator;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         cmd_error;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] D_CAFE = 128'h0123_4567_89AB_CDEF_0011_2233_CAFE_BABE;
  localparam logic [127:0] D_PRIO = 128'hA5A5_A5A5_5A5A_5A5A_DEAD_BEEF_0BAD_F00D;
  localparam logic [127:0] D_PART = 128'h0000_0000_0000_0000_0000_0000_1234_5678;
  localparam logic [127:0] D_MRG  = 128'hA5A5_A5A5_5A5A_5A5A_DEAD_BEEF_1234_5678;
  localparam logic [127:0] D0 = 128'h1000_0000_0000_0000_0000_0000_0000_00A0;
  localparam logic [127:0] D1 = 128'h2111_1111_1111_1111_1111_1111_1111_11A1;
  localparam logic [127:0] D2 = 128'h3222_2222_2222_2222_2222_2222_2222_22A2;
  localparam logic [127:0] D3 = 128'h4333_3333_3333_3333_3333_3333_3333_33A3;

  mig_ui_emulator dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_error           (cmd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [127:0] data, input logic [15:0] mask);
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = data;
    app_wdf_mask = mask;
  endtask

  task automatic idle_data();
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  // Single read; checks the valid/end pulse lands exactly 4 cycles after acceptance.
  task automatic do_read(input logic [27:0] addr, input logic [127:0] exp, input string tag);
    check({tag, "_rdy"}, 128'(app_rdy), 128'(1));
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = addr;
    step();
    app_en = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("%s_vld%0d", tag, j), 128'(app_rd_data_valid), 128'(j == 3));
    end
    check({tag, "_data"}, app_rd_data, exp);
    check({tag, "_end"}, 128'(app_rd_data_end), 128'(1));
    step();
    check({tag, "_vld_off"}, 128'(app_rd_data_valid), 128'(0));
  endtask

  task automatic do_write_cmd(input logic [27:0] addr);
    app_en   = 1'b1;
    app_cmd  = 3'b000;
    app_addr = addr;
  endtask

  initial begin
    reset_n = 1'b0;
    app_addr = '0; app_cmd = '0; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_rdy", 128'(app_rdy), 128'(0));
    check("rst_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
    check("rst_calib", 128'(init_calib_complete), 128'(0));
    check("rst_vld", 128'(app_rd_data_valid), 128'(0));
    check("rst_err", 128'(cmd_error), 128'(0));

    // Calibration: all three readies rise on the 16th edge after release
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("calib_%0d", i), 128'(init_calib_complete), 128'(i >= 16));
      if (i >= 15) begin
        check($sformatf("calib_rdy_%0d", i), 128'(app_rdy), 128'(i >= 16));
        check($sformatf("calib_wdf_%0d", i), 128'(app_wdf_rdy), 128'(i >= 16));
      end
    end

    // Data first, command next cycle
    push_beat(D_CAFE, 16'h0000);
    step();
    idle_data();
    do_write_cmd(28'd100);
    step();
    app_en = 1'b0;
    do_read(28'd100, D_CAFE, "wr_data_first");
    check("cafe_low32", 128'(app_rd_data[31:0]), 128'(32'hCAFEBABE));

    // Known prior line (data and command together), then command before data
    push_beat(D_PRIO, 16'h0000);
    do_write_cmd(28'd200);
    step();
    idle_data();
    app_en = 1'b0;
    do_write_cmd(28'd200);
    step();
    app_en = 1'b0;
    check("wait_rdy_low", 128'(app_rdy), 128'(0));
    step();
    check("wait_rdy_hold", 128'(app_rdy), 128'(0));
    push_beat(D_PART, 16'hFFF0);
    step();
    idle_data();
    check("wait_rdy_back", 128'(app_rdy), 128'(1));
    do_read(28'd200, D_MRG, "masked");

    // Fill the buffer with no command
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_wdf_rdy%0d", i), 128'(app_wdf_rdy), 128'(1));
      case (i)
        0: push_beat(D0, 16'h0000);
        1: push_beat(D1, 16'h0000);
        2: push_beat(D2, 16'h0000);
        default: push_beat(D3, 16'h0000);
      endcase
      step();
    end
    idle_data();
    check("full_wdf_rdy", 128'(app_wdf_rdy), 128'(0));

    // Four writes drain it in FIFO order, no bubbles
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_rdy%0d", i), 128'(app_rdy), 128'(1));
      do_write_cmd(28'(i * 8));
      step();
    end
    app_en = 1'b0;
    check("drained_wdf_rdy", 128'(app_wdf_rdy), 128'(1));

    // Back-to-back reads at 0, 8, 16
    app_en = 1'b1; app_cmd = 3'b001;
    app_addr = 28'd0;  step();
    app_addr = 28'd8;  step();
    app_addr = 28'd16; step();
    app_en = 1'b0;
    step();
    check("pipe0_vld", 128'(app_rd_data_valid), 128'(1));
    check("pipe0_data", app_rd_data, D0);
    step();
    check("pipe1_vld", 128'(app_rd_data_valid), 128'(1));
    check("pipe1_data", app_rd_data, D1);
    step();
    check("pipe2_vld", 128'(app_rd_data_valid), 128'(1));
    check("pipe2_data", app_rd_data, D2);
    step();
    check("pipe_off", 128'(app_rd_data_valid), 128'(0));

    do_read(28'd24, D3, "line3");
    do_read(28'd8 << 10, D0, "alias");

    // Illegal command: sticky error, memory untouched
    app_en = 1'b1; app_cmd = 3'b010; app_addr = 28'd0;
    app_wdf_data = D3;
    step();
    app_en = 1'b0;
    check("ill_err", 128'(cmd_error), 128'(1));
    step();
    check("ill_err_sticky", 128'(cmd_error), 128'(1));
    do_read(28'd0, D0, "ill_nochg");

    // Reset one cycle after read acceptance drops the response
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'd8;
    step();
    app_en = 1'b0;
    reset_n = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("rst_mid_vld%0d", i), 128'(app_rd_data_valid), 128'(0));
    end
    check("rst_mid_end", 128'(app_rd_data_end), 128'(0));
    check("rst_mid_data", app_rd_data, 128'(0));
    check("rst_mid_rdy", 128'(app_rdy), 128'(0));
    check("rst_mid_wdf", 128'(app_wdf_rdy), 128'(0));
    check("rst_mid_calib", 128'(init_calib_complete), 128'(0));
    check("rst_mid_err", 128'(cmd_error), 128'(0));
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
